// File: rtl/usb_pkg.sv
// Shared definitions for the USB full-speed transmit path: packet request codes,
// transmitter states, PID/SYNC bytes and the CRC16 helper.
package usb_pkg;

  typedef enum logic [2:0] {
    PKT_OUT   = 3'd0,
    PKT_IN    = 3'd1,
    PKT_DATA0 = 3'd2,
    PKT_DATA1 = 3'd3,
    PKT_ACK   = 3'd4,
    PKT_NAK   = 3'd5,
    PKT_STALL = 3'd6,
    PKT_NONE  = 3'd7
  } tx_packet_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PID,
    ST_DATA,
    ST_CRC_LO,
    ST_CRC_HI,
    ST_EOP_SE0,
    ST_EOP_J
  } tx_state_e;

  localparam logic [7:0]  SYNC_BYTE  = 8'h80;
  localparam logic [7:0]  PID_DATA0  = 8'hC3;
  localparam logic [7:0]  PID_DATA1  = 8'h4B;
  localparam logic [7:0]  PID_ACK    = 8'hD2;
  localparam logic [7:0]  PID_NAK    = 8'h5A;
  localparam logic [7:0]  PID_STALL  = 8'h1E;
  localparam logic [15:0] CRC16_POLY = 16'h8005;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  function automatic logic [7:0] pid_for(input tx_packet_e pkt);
    logic [7:0] pid;
    case (pkt)
      PKT_DATA0: pid = PID_DATA0;
      PKT_DATA1: pid = PID_DATA1;
      PKT_ACK:   pid = PID_ACK;
      PKT_NAK:   pid = PID_NAK;
      default:   pid = PID_STALL;
    endcase
    return pid;
  endfunction

  // Reflected CRC16 update, consuming the byte LSB-first as it goes on the wire
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] poly_ref;
    logic [15:0] c;
    logic        fb;
    for (int i = 0; i < 16; i++) poly_ref[i] = CRC16_POLY[15-i];
    c = crc;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ data[i];
      c  = c >> 1;
      if (fb) c = c ^ poly_ref;
    end
    return c;
  endfunction

endpackage

// File: rtl/usb_data_buffer.sv
// Circular byte FIFO shared by the host, the RX packet path and the transmitter.
// Two write ports (RX path has priority), one read port, flush overrides everything.
module usb_data_buffer
  import usb_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic [7:0]             tx_data,
  input  logic                   store_tx_data,
  input  logic [7:0]             rx_packet_data,
  input  logic                   store_rx_packet_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [7:0]             head,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [7:0]    wr_byte;
  logic          do_push;
  logic          do_pop;

  assign wr_byte = store_rx_packet_data ? rx_packet_data : tx_data;
  assign do_push = (store_rx_packet_data || store_tx_data) && (occupancy != CNT_MAX) && !flush;
  assign do_pop  = pop && (occupancy != '0) && !flush;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_byte;
  end

  always_ff @(posedge clk) begin
    if (n_rst || flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   occupancy <= occupancy + CNT_ONE;
        2'b01:   occupancy <= occupancy - CNT_ONE;
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: rtl/usb_tx_db.sv
// USB full-speed transmitter with shared data buffer: serialises SYNC, PID,
// payload and CRC16 with NRZI and bit stuffing, then drives EOP.
module usb_tx_db
  import usb_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int BUF_DEPTH    = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] tx_data,
  input  logic       store_tx_data,
  input  logic [7:0] rx_packet_data,
  input  logic       store_rx_packet_data,
  input  logic       get_rx_data,
  input  logic [2:0] tx_packet,
  input  logic       flush,
  input  logic       clear,
  output logic [6:0] buffer_occupancy,
  output logic [7:0] rx_data,
  output logic       dp_out,
  output logic       dm_out,
  output logic       tx_transfer_active,
  output logic       tx_error
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] TICK_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CLK_ONE   = CW'(1);

  tx_state_e    state, state_n;
  tx_packet_e   pkt;
  logic [CW-1:0] clk_cnt, clk_cnt_n;
  logic [2:0]   bit_cnt, bit_cnt_n;
  logic [6:0]   byte_cnt, byte_cnt_n;
  logic [7:0]   cur_byte, cur_byte_n;
  logic [7:0]   pid, pid_n;
  logic [2:0]   ones_cnt, ones_cnt_n, ones_next;
  logic         stuffing, stuffing_n;
  logic         line_j, line_j_n;
  logic         se0, se0_n;
  logic [15:0]  crc, crc_n;
  logic         is_data, is_data_n;
  logic [2:0]   prev_pkt;
  logic         tx_error_n;
  logic         accept, tick, cur_bit;
  logic         pop_host, pop_tx;
  logic         do_emit, emit_bit;
  logic [7:0]   head;

  usb_data_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk                  (clk),
    .n_rst                (n_rst),
    .tx_data              (tx_data),
    .store_tx_data        (store_tx_data),
    .rx_packet_data       (rx_packet_data),
    .store_rx_packet_data (store_rx_packet_data),
    .pop                  (pop_host || pop_tx),
    .flush                (flush || clear),
    .head                 (head),
    .occupancy            (buffer_occupancy)
  );

  assign pkt                = tx_packet_e'(tx_packet);
  assign tx_transfer_active = (state != ST_IDLE);
  assign pop_host           = get_rx_data && (state == ST_IDLE) && (buffer_occupancy != '0);
  assign accept             = (state == ST_IDLE) && (pkt != PKT_NONE) && (prev_pkt == 3'd7);
  assign tick               = (clk_cnt == TICK_LAST);
  assign cur_bit            = stuffing ? 1'b0 : cur_byte[bit_cnt];
  assign dp_out             = se0 ? 1'b0 : line_j;
  assign dm_out             = se0 ? 1'b0 : !line_j;

  always_ff @(posedge clk) begin
    if (n_rst) begin
      state    <= ST_IDLE;
      clk_cnt  <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      cur_byte <= '0;
      pid      <= '0;
      ones_cnt <= '0;
      stuffing <= 1'b0;
      line_j   <= 1'b1;
      se0      <= 1'b0;
      crc      <= CRC16_INIT;
      is_data  <= 1'b0;
      prev_pkt <= 3'd7;
      tx_error <= 1'b0;
      rx_data  <= '0;
    end else begin
      state    <= state_n;
      clk_cnt  <= clk_cnt_n;
      bit_cnt  <= bit_cnt_n;
      byte_cnt <= byte_cnt_n;
      cur_byte <= cur_byte_n;
      pid      <= pid_n;
      ones_cnt <= ones_cnt_n;
      stuffing <= stuffing_n;
      line_j   <= line_j_n;
      se0      <= se0_n;
      crc      <= crc_n;
      is_data  <= is_data_n;
      prev_pkt <= tx_packet;
      tx_error <= tx_error_n;
      if (pop_host && !flush && !clear) rx_data <= head;
    end
  end

  // Registers describe the bit currently on the line; on each bit-time boundary
  // the next bit (data or stuffed 0) is chosen and NRZI-encoded.
  always_comb begin
    state_n    = state;
    clk_cnt_n  = clk_cnt;
    bit_cnt_n  = bit_cnt;
    byte_cnt_n = byte_cnt;
    cur_byte_n = cur_byte;
    pid_n      = pid;
    ones_cnt_n = ones_cnt;
    stuffing_n = stuffing;
    line_j_n   = line_j;
    se0_n      = se0;
    crc_n      = crc;
    is_data_n  = is_data;
    tx_error_n = 1'b0;
    pop_tx     = 1'b0;
    do_emit    = 1'b0;
    emit_bit   = 1'b1;
    ones_next  = cur_bit ? ones_cnt + 3'd1 : 3'd0;

    if (clear) begin
      state_n    = ST_IDLE;
      clk_cnt_n  = '0;
      bit_cnt_n  = '0;
      ones_cnt_n = '0;
      stuffing_n = 1'b0;
      line_j_n   = 1'b1;
      se0_n      = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (pkt == PKT_OUT || pkt == PKT_IN) begin
              tx_error_n = 1'b1;
            end else begin
              state_n    = ST_SYNC;
              clk_cnt_n  = '0;
              bit_cnt_n  = '0;
              ones_cnt_n = '0;
              stuffing_n = 1'b0;
              cur_byte_n = SYNC_BYTE;
              pid_n      = pid_for(pkt);
              crc_n      = CRC16_INIT;
              is_data_n  = (pkt == PKT_DATA0) || (pkt == PKT_DATA1);
              byte_cnt_n = is_data_n ? buffer_occupancy - (pop_host ? 7'd1 : 7'd0) : 7'd0;
              do_emit    = 1'b1;
              emit_bit   = SYNC_BYTE[0];
            end
          end
        end
        ST_EOP_SE0: begin
          if (tick) begin
            if (bit_cnt == 3'd0) begin
              bit_cnt_n = 3'd1;
            end else begin
              bit_cnt_n = '0;
              state_n   = ST_EOP_J;
              se0_n     = 1'b0;
              line_j_n  = 1'b1;
            end
          end
        end
        ST_EOP_J: begin
          if (tick) state_n = ST_IDLE;
        end
        default: begin
          if (tick) begin
            if (!stuffing && ones_next == 3'd6) begin
              stuffing_n = 1'b1;
              ones_cnt_n = '0;
              do_emit    = 1'b1;
              emit_bit   = 1'b0;
            end else begin
              stuffing_n = 1'b0;
              ones_cnt_n = ones_next;
              if (bit_cnt != 3'd7) begin
                bit_cnt_n = bit_cnt + 3'd1;
                do_emit   = 1'b1;
                emit_bit  = cur_byte[bit_cnt_n];
              end else begin
                bit_cnt_n = '0;
                case (state)
                  ST_SYNC: begin
                    state_n    = ST_PID;
                    cur_byte_n = pid;
                  end
                  ST_PID, ST_DATA: begin
                    if (state == ST_PID && !is_data) begin
                      state_n = ST_EOP_SE0;
                    end else if (byte_cnt != 7'd0) begin
                      state_n    = ST_DATA;
                      cur_byte_n = head;
                      pop_tx     = 1'b1;
                      crc_n      = crc16_byte(crc, head);
                      byte_cnt_n = byte_cnt - 7'd1;
                    end else begin
                      state_n    = ST_CRC_LO;
                      cur_byte_n = ~crc[7:0];
                    end
                  end
                  ST_CRC_LO: begin
                    state_n    = ST_CRC_HI;
                    cur_byte_n = ~crc[15:8];
                  end
                  default: state_n = ST_EOP_SE0;
                endcase
                if (state_n == ST_EOP_SE0) begin
                  se0_n = 1'b1;
                end else begin
                  do_emit  = 1'b1;
                  emit_bit = cur_byte_n[0];
                end
              end
            end
          end
        end
      endcase
      if (state != ST_IDLE) clk_cnt_n = tick ? '0 : clk_cnt + CLK_ONE;
    end

    if (do_emit) line_j_n = emit_bit ? line_j : !line_j;
  end

endmodule

// File: tb/tb_usb_tx_db.sv
// Directed self-checking bench for usb_tx_db: decodes the NRZI/stuffed line
// and compares against a bit-serial reference stream built here.
module tb_usb_tx_db;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [7:0] tx_data;
  logic       store_tx_data;
  logic [7:0] rx_packet_data;
  logic       store_rx_packet_data;
  logic       get_rx_data;
  logic [2:0] tx_packet;
  logic       flush;
  logic       clear;
  logic [6:0] buffer_occupancy;
  logic [7:0] rx_data;
  logic       dp_out;
  logic       dm_out;
  logic       tx_transfer_active;
  logic       tx_error;

  int         checks = 0;
  int         failures = 0;
  bit         cap_bits[$];
  bit         exp_bits[$];
  int         nstuff;
  int         stuff_err;
  int         active_cycles;
  bit         se0_seen;
  logic [15:0] model_crc;

  always #5 clk = ~clk;

  usb_tx_db #(.CLKS_PER_BIT(CPB), .BUF_DEPTH(64)) dut (
    .clk                  (clk),
    .n_rst                (n_rst),
    .tx_data              (tx_data),
    .store_tx_data        (store_tx_data),
    .rx_packet_data       (rx_packet_data),
    .store_rx_packet_data (store_rx_packet_data),
    .get_rx_data          (get_rx_data),
    .tx_packet            (tx_packet),
    .flush                (flush),
    .clear                (clear),
    .buffer_occupancy     (buffer_occupancy),
    .rx_data              (rx_data),
    .dp_out               (dp_out),
    .dm_out               (dm_out),
    .tx_transfer_active   (tx_transfer_active),
    .tx_error             (tx_error)
  );

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One cycle of strobes; tx_packet is left at the given value afterwards
  task automatic applyStimulus(input logic [2:0] pkt, input logic push_rx, input logic push_tx,
                               input logic [7:0] d, input logic get, input logic fl);
    tx_packet            = pkt;
    store_rx_packet_data = push_rx;
    rx_packet_data       = d;
    store_tx_data        = push_tx;
    tx_data              = d;
    get_rx_data          = get;
    flush                = fl;
    @(negedge clk);
    store_rx_packet_data = 1'b0;
    store_tx_data        = 1'b0;
    get_rx_data          = 1'b0;
    flush                = 1'b0;
  endtask

  task automatic addByte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
  endtask

  task automatic addPayload(input logic [7:0] b);
    logic fb;
    for (int i = 0; i < 8; i++) begin
      fb        = b[i] ^ model_crc[15];
      model_crc = {model_crc[14:0], 1'b0};
      if (fb) model_crc = model_crc ^ 16'h8005;
      exp_bits.push_back(b[i]);
    end
  endtask

  task automatic addCrc();
    for (int i = 15; i >= 0; i--) exp_bits.push_back(~model_crc[i]);
  endtask

  function automatic int expStuffs();
    int run = 0;
    int n = 0;
    foreach (exp_bits[i]) begin
      run = exp_bits[i] ? run + 1 : 0;
      if (run == 6) begin
        n++;
        run = 0;
      end
    end
    return n;
  endfunction

  function automatic logic [7:0] capByte(input int k);
    logic [7:0] b = '0;
    for (int i = 0; i < 8; i++)
      if (8 * k + i < cap_bits.size()) b[i] = cap_bits[8 * k + i];
    return b;
  endfunction

  // Waits for the frame, samples mid-bit, undoes NRZI and removes stuffed bits
  task automatic captureFrame();
    bit seen = 0;
    bit prev_j = 1;
    bit b;
    int run = 0;
    int c = 0;
    cap_bits.delete();
    nstuff = 0;
    stuff_err = 0;
    active_cycles = 0;
    se0_seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (tx_transfer_active) seen = 1;
    end
    checkOutput("active_rise", 32'(seen), 1);
    if (!seen) return;
    while (tx_transfer_active && c < 8000) begin
      active_cycles++;
      if (c % CPB == CPB / 2 && !se0_seen) begin
        if (!dp_out && !dm_out) begin
          se0_seen = 1;
        end else begin
          b = (dp_out == prev_j);
          prev_j = dp_out;
          if (run == 6) begin
            if (b) stuff_err++;
            nstuff++;
            run = 0;
          end else begin
            cap_bits.push_back(b);
            run = b ? run + 1 : 0;
          end
        end
      end
      c++;
      @(negedge clk);
    end
    checkOutput("frame_bounded", 32'(c < 8000), 1);
  endtask

  task automatic checkFrame(input string tag);
    int mism = 0;
    int es;
    checkOutput({tag, "_nbits"}, cap_bits.size(), exp_bits.size());
    for (int i = 0; i < exp_bits.size() && i < cap_bits.size(); i++)
      if (cap_bits[i] != exp_bits[i]) mism++;
    checkOutput({tag, "_bitstream"}, mism, 0);
    es = expStuffs();
    checkOutput({tag, "_stuffs"}, nstuff, es);
    checkOutput({tag, "_stuff_zero"}, stuff_err, 0);
    checkOutput({tag, "_active_cycles"}, active_cycles, (exp_bits.size() + es + 3) * CPB);
    checkOutput({tag, "_se0"}, 32'(se0_seen), 1);
    checkOutput({tag, "_idle_line"}, {30'd0, dp_out, dm_out}, 32'b10);
  endtask

  initial begin
    int cnt;
    n_rst = 1'b1;
    tx_packet = 3'd7;
    tx_data = '0;
    rx_packet_data = '0;
    store_tx_data = 1'b0;
    store_rx_packet_data = 1'b0;
    get_rx_data = 1'b0;
    flush = 1'b0;
    clear = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_occupancy", buffer_occupancy, 0);
    checkOutput("rst_dp", dp_out, 1);
    checkOutput("rst_dm", dm_out, 0);
    checkOutput("rst_active", tx_transfer_active, 0);
    checkOutput("rst_tx_error", tx_error, 0);
    checkOutput("rst_rx_data", rx_data, 8'h00);
    n_rst = 1'b0;
    @(negedge clk);

    $display("[TB] DATA0 with one byte from the RX path");
    applyStimulus(3'd7, 1'b1, 1'b0, 8'h64, 1'b0, 1'b0);
    checkOutput("d0a_occ_before", buffer_occupancy, 1);
    exp_bits.delete();
    addByte(8'h80);
    addByte(8'hC3);
    model_crc = 16'hFFFF;
    addPayload(8'h64);
    addCrc();
    tx_packet = 3'd2;
    captureFrame();
    checkFrame("d0a");
    checkOutput("d0a_pid", capByte(1), 8'hC3);
    checkOutput("d0a_payload", capByte(2), 8'h64);
    checkOutput("d0a_occ_after", buffer_occupancy, 0);
    applyStimulus(3'd7, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    $display("[TB] DATA0 with five host bytes");
    for (int i = 0; i < 5; i++) applyStimulus(3'd7, 1'b0, 1'b1, 8'(8'h64 + i), 1'b0, 1'b0);
    checkOutput("d0b_occ_before", buffer_occupancy, 5);
    exp_bits.delete();
    addByte(8'h80);
    addByte(8'hC3);
    model_crc = 16'hFFFF;
    for (int i = 0; i < 5; i++) addPayload(8'(8'h64 + i));
    addCrc();
    tx_packet = 3'd2;
    captureFrame();
    checkFrame("d0b");
    for (int i = 0; i < 5; i++) checkOutput($sformatf("d0b_payload%0d", i), capByte(2 + i), 32'h64 + i);
    checkOutput("d0b_occ_after", buffer_occupancy, 0);
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (tx_transfer_active) cnt++;
    end
    checkOutput("d0b_no_retransmit", cnt, 0);
    applyStimulus(3'd7, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    $display("[TB] ACK handshake");
    exp_bits.delete();
    addByte(8'h80);
    addByte(8'hD2);
    tx_packet = 3'd4;
    captureFrame();
    checkFrame("ack");
    checkOutput("ack_active_152", active_cycles, 152);
    checkOutput("ack_no_stuff", nstuff, 0);
    checkOutput("ack_pid", capByte(1), 8'hD2);
    applyStimulus(3'd7, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    $display("[TB] DATA1 with 0xFF payload (bit stuffing)");
    applyStimulus(3'd7, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
    exp_bits.delete();
    addByte(8'h80);
    addByte(8'h4B);
    model_crc = 16'hFFFF;
    addPayload(8'hFF);
    addCrc();
    tx_packet = 3'd3;
    captureFrame();
    checkFrame("d1ff");
    checkOutput("d1ff_has_stuff", 32'(nstuff >= 1), 1);
    checkOutput("d1ff_pid", capByte(1), 8'h4B);
    checkOutput("d1ff_payload", capByte(2), 8'hFF);
    applyStimulus(3'd7, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    $display("[TB] Buffer full, host pop, flush, invalid request");
    for (int i = 0; i < 64; i++) applyStimulus(3'd7, 1'b0, 1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
    checkOutput("full_occ", buffer_occupancy, 64);
    applyStimulus(3'd7, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0);
    checkOutput("full_push_ignored", buffer_occupancy, 64);
    applyStimulus(3'd7, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("pop_rx_data", rx_data, 8'hA0);
    checkOutput("pop_occ", buffer_occupancy, 63);
    applyStimulus(3'd7, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("flush_occ", buffer_occupancy, 0);
    applyStimulus(3'd1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("in_tx_error_pulse", tx_error, 1);
    checkOutput("in_active_low", tx_transfer_active, 0);
    @(negedge clk);
    checkOutput("in_tx_error_clear", tx_error, 0);
    checkOutput("in_active_still_low", tx_transfer_active, 0);
    tx_packet = 3'd7;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/usb_tx_db.md
Name: usb_tx_db

Overview:
- USB full-speed transmit path with a shared 64-byte data buffer.
- The buffer is filled from the host side (tx_data) or the RX packet path (rx_packet_data), and drained either by a host read (get_rx_data) or by the transmitter.
- The transmitter serialises DATA0/DATA1/ACK/NAK/STALL packets onto dp_out/dm_out: SYNC, PID, payload, CRC16, NRZI encoding, bit stuffing, EOP.

Parameters:
- CLKS_PER_BIT, 8, clk cycles per USB bit time.
- BUF_DEPTH, 64, buffer depth in bytes (power of two).

Ports:
- clk  in  1  system clock.
- n_rst  in  1  synchronous reset, active-high (1 = reset, sampled on rising clk).
- tx_data  in  8  host byte to buffer.
- store_tx_data  in  1  push tx_data this cycle.
- rx_packet_data  in  8  RX-path byte to buffer.
- store_rx_packet_data  in  1  push rx_packet_data this cycle.
- get_rx_data  in  1  pop head byte to rx_data.
- tx_packet  in  3  packet request; encoding in Behaviour.
- flush  in  1  empty the buffer.
- clear  in  1  empty the buffer and abort any transmission.
- buffer_occupancy  out  7  byte count, 0..64.
- rx_data  out  8  last popped byte (registered).
- dp_out  out  1  D+ line.
- dm_out  out  1  D- line.
- tx_transfer_active  out  1  high while a packet is on the line.
- tx_error  out  1  one-cycle pulse on an invalid request.

Behaviour:
- Reset values: occupancy 0, pointers 0, rx_data 0x00, dp_out 1 / dm_out 0 (idle J), tx_transfer_active 0, tx_error 0, transmitter IDLE.
- Buffer: circular FIFO.
  - Push priority: store_rx_packet_data over store_tx_data; only one push per cycle.
  - Push while full is ignored.
  - Writes are visible in occupancy the next cycle.
- get_rx_data:
  - Non-empty: rx_data <= head on the next edge and the entry is popped (1-cycle latency).
  - Empty: rx_data holds its value.
  - Ignored while tx_transfer_active.
- Simultaneous push and pop in the same cycle leaves occupancy unchanged.
- flush and clear: occupancy and pointers go to 0 next cycle and override a same-cycle push or pop.
  - clear additionally returns the transmitter to IDLE, with the line at J and active=0.
- tx_packet codes: 0 OUT, 1 IN, 2 DATA0, 3 DATA1, 4 ACK, 5 NAK, 6 STALL, 7 none.
  - A request is accepted only in IDLE, on a cycle where tx_packet != 7 and the previous cycle's value was 7 (edge-triggered).
  - Holding the code after completion does not retransmit.
  - OUT or IN: no transmission; tx_error pulses 1 cycle.
- tx_transfer_active rises the cycle after acceptance and falls after the last EOP bit time.
- Packet order:
  - SYNC: 0x80, sent LSB-first.
  - PID byte, LSB-first: DATA0 0xC3, DATA1 0x4B, ACK 0xD2, NAK 0x5A, STALL 0x1E.
  - DATA0/DATA1 only: payload = every byte present at acceptance (the count is latched), popped one per byte, LSB-first; a zero-length payload is legal.
  - DATA0/DATA1 only: CRC16 over the payload, poly 0x8005 (x^16+x^15+x^2+1), reflected, init 0xFFFF; the complement is sent LSB-first.
  - EOP: SE0 (dp=0, dm=0) for 2 bit times, then J for 1 bit time, then IDLE.
- NRZI: a 0 toggles the line, a 1 holds it. The J level is dp=1/dm=0 and K is dp=0/dm=1. Each bit is held for CLKS_PER_BIT cycles.
- Bit stuffing: after six consecutive 1s (counted from SYNC through CRC), insert a 0 bit time. EOP is not stuffed.
- FSM states: IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, EOP_SE0, EOP_J.
  - ACK/NAK/STALL go PID -> EOP_SE0.
  - Bit counters are 3-bit and the byte counter is 7-bit.
- Pushes during transmission are accepted. The latched count excludes them, so they remain in the buffer.

Decomposition:
- Shared package usb_pkg: tx_packet enum (OUT..STALL, NONE=7), PID constants, SYNC constant, CRC16 polynomial/init constants.
- One sub-module: usb_data_buffer (FIFO with occupancy, flush, two write ports, one read port).
- The transmitter FSM, NRZI encoder, stuffing and CRC stay in usb_tx_db.

Test Plan:
- Reset: assert n_rst=1 for 2 cycles -> occupancy 0, dp=1, dm=0, active=0, tx_error=0, rx_data=0x00.
- Push 1 byte 0x64 via store_rx_packet_data, then DATA0 (2) -> occupancy 1 then 0.
  - Line carries SYNC, PID 0xC3, 0x64, CRC16 matching a bit-level model, EOP; active falls; dp=1/dm=0 after.
- Push 0x64..0x68 (5 bytes) via store_tx_data, return tx_packet to 7, then DATA0 -> occupancy 5.
  - Decoded payload is 64 65 66 67 68 and occupancy ends at 0.
  - Holding tx_packet=2 afterwards does not retransmit.
- ACK (4) with CLKS_PER_BIT=8 -> active for exactly 19 bit times (152 cycles), no stuffed bits, PID decodes 0xD2.
- DATA1 with payload 0xFF -> a stuffed 0 appears after the 6th consecutive 1; the decoder recovers 0xFF and the CRC checks.
- Fill 64 bytes, push a 65th -> occupancy stays 64.
  - get_rx_data -> rx_data=first byte, occupancy 63.
  - flush -> 0.
  - Request IN (1) -> tx_error pulses 1 cycle, active stays 0.
